// File: rtl/steer_en_sm_pkg.sv
// rtl/steer_en_sm_pkg.sv - shared types and constants for the steering-enable state machine
package steer_en_sm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STEER = 2'd2
    } steer_state_t;

    // Rider weight threshold and the hysteresis band around it (13-bit load sums)
    localparam logic [12:0] MIN_RIDER_WT = 13'h200;
    localparam logic [12:0] WT_HYST      = 13'h040;

    // Full balance timer width and the shortened width used for fast simulation
    localparam int TMR_W      = 26;
    localparam int TMR_FAST_W = 15;

endpackage

// File: rtl/steer_tmr.sv
// rtl/steer_tmr.sv - balance qualification timer with selectable terminal count
module steer_tmr
    import steer_en_sm_pkg::*;
#(
    parameter logic fast_sim = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tmr_full
);

    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;

    // Clear has priority over counting; the count holds when not enabled
    always_comb begin
        tmr_d = tmr_q;
        if (clr) begin
            tmr_d = '0;
        end else if (en) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    // Timer register, cleared by reset so no count survives an abandoned qualification
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    assign tmr_full = fast_sim ? (&tmr_q[TMR_FAST_W-1:0]) : (&tmr_q);

endmodule

// File: rtl/steer_en_sm.sv
// rtl/steer_en_sm.sv - rider detection and balance qualification FSM driving steering enable
module steer_en_sm
    import steer_en_sm_pkg::*;
#(
    parameter logic fast_sim = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
);

    localparam logic [12:0] SUM_ON_THR  = MIN_RIDER_WT + WT_HYST;
    localparam logic [12:0] SUM_OFF_THR = MIN_RIDER_WT - WT_HYST;

    steer_state_t       state_q;
    steer_state_t       state_d;
    logic               tmr_clr;
    logic               tmr_en;
    logic               tmr_full;

    logic [12:0]        sum;
    logic signed [12:0] diff_s;
    logic [11:0]        diff;
    logic               sum_gt_min;
    logic               sum_lt_min;
    logic               diff_gt_1_4;
    logic               diff_gt_15_16;

    // Load-cell sum, absolute difference and the threshold comparisons
    always_comb begin
        sum           = {1'b0, lft_ld} + {1'b0, rght_ld};
        diff_s        = $signed({1'b0, lft_ld}) - $signed({1'b0, rght_ld});
        diff          = diff_s[12] ? 12'(-diff_s) : 12'(diff_s);
        sum_gt_min    = sum > SUM_ON_THR;
        sum_lt_min    = sum < SUM_OFF_THR;
        diff_gt_1_4   = {1'b0, diff} > (sum >> 2);
        diff_gt_15_16 = {1'b0, diff} > (sum - (sum >> 4));
    end

    // Next-state and timer control; dismount always takes priority
    always_comb begin
        state_d = state_q;
        tmr_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sum_gt_min) begin
                    state_d = WAIT;
                    tmr_clr = 1'b1;
                end
            end
            WAIT: begin
                if (sum_lt_min) begin
                    state_d = IDLE;
                end else if (diff_gt_1_4) begin
                    tmr_clr = 1'b1;
                end else if (tmr_full) begin
                    state_d = STEER;
                end
            end
            STEER: begin
                if (sum_lt_min) begin
                    state_d = IDLE;
                end else if (diff_gt_15_16) begin
                    state_d = WAIT;
                    tmr_clr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign tmr_en = (state_q == WAIT);

    steer_tmr #(
        .fast_sim (fast_sim)
    ) u_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .tmr_full (tmr_full)
    );

    assign en_steer  = (state_q == STEER);
    assign rider_off = (state_q == IDLE);

endmodule

// File: tb/tb_steer_en_sm.sv
// tb/tb_steer_en_sm.sv - directed self-checking bench for steer_en_sm with the fast timer
module tb_steer_en_sm;

    logic        clk;
    logic        rst_n;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        en_steer;
    logic        rider_off;

    int n_tests;
    int n_fail;

    localparam int FULL_CNT = 32768;

    steer_en_sm #(
        .fast_sim (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .en_steer  (en_steer),
        .rider_off (rider_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] lft;
        logic [11:0] rght;
        logic        exp_en;
        logic        exp_off;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic exp_en, input logic exp_off);
        check({name, ".en_steer"}, int'(en_steer), int'(exp_en));
        check({name, ".rider_off"}, int'(rider_off), int'(exp_off));
    endtask

    task automatic count_to_steer(output int n);
        n = 0;
        while (en_steer == 1'b0 && n < 40000) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int bad;
        n_tests = 0;
        n_fail  = 0;

        // IDLE hysteresis and threshold edges, including a sum that needs bit 12
        vecs[0] = '{12'h100, 12'h100, 1'b0, 1'b1};
        vecs[1] = '{12'h120, 12'h120, 1'b0, 1'b1};
        vecs[2] = '{12'h121, 12'h120, 1'b0, 1'b0};
        vecs[3] = '{12'h100, 12'h0C0, 1'b0, 1'b0};
        vecs[4] = '{12'h0E0, 12'h0DF, 1'b0, 1'b1};
        vecs[5] = '{12'h800, 12'h800, 1'b0, 1'b0};
        vecs[6] = '{12'h000, 12'h300, 1'b0, 1'b0};
        vecs[7] = '{12'h000, 12'h000, 1'b0, 1'b1};

        // Reset held for two clocks with a rider-level load
        rst_n   = 1'b0;
        lft_ld  = 12'h300;
        rght_ld = 12'h300;
        step();
        check_out("rst_clk1", 1'b0, 1'b1);
        step();
        check_out("rst_clk2", 1'b0, 1'b1);
        rst_n = 1'b1;
        check_out("rst_release", 1'b0, 1'b1);
        step();
        check_out("post_rst_wait", 1'b0, 1'b0);

        // Partial qualification abandoned by reset
        repeat (5000) step();
        rst_n = 1'b0;
        step();
        check_out("rst_mid_wait", 1'b0, 1'b1);
        lft_ld  = 12'h000;
        rght_ld = 12'h000;
        step();
        rst_n = 1'b1;
        step();
        check_out("idle_after_rst", 1'b0, 1'b1);

        // Table of single-clock transitions
        for (int i = 0; i < 8; i++) begin
            lft_ld  = vecs[i].lft;
            rght_ld = vecs[i].rght;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].exp_en, vecs[i].exp_off);
        end

        // Balanced mount: full count from the first WAIT cycle, no residue from the earlier reset
        lft_ld  = 12'h180;
        rght_ld = 12'h180;
        step();
        check_out("mount", 1'b0, 1'b0);
        count_to_steer(n);
        check("mount_latency", n, FULL_CNT);
        check_out("steer", 1'b1, 1'b0);

        // Large imbalance drops STEER back to WAIT
        lft_ld  = 12'h2F0;
        rght_ld = 12'h008;
        step();
        check_out("steer_drop", 1'b0, 1'b0);
        repeat (20) step();

        // Hysteresis band in WAIT keeps qualifying
        lft_ld  = 12'h100;
        rght_ld = 12'h100;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (en_steer !== 1'b0 || rider_off !== 1'b0) bad++;
        end
        check("wait_hyst_hold", bad, 0);

        // Single-clock imbalance after 10000 WAIT clocks restarts the count
        lft_ld  = 12'h180;
        rght_ld = 12'h180;
        repeat (10000) step();
        check_out("pre_imbal", 1'b0, 1'b0);
        lft_ld  = 12'h200;
        rght_ld = 12'h100;
        step();
        lft_ld  = 12'h180;
        rght_ld = 12'h180;
        count_to_steer(n);
        check("imbal_latency", n, FULL_CNT);

        // Dismount with a large difference: leaving for IDLE wins
        lft_ld  = 12'h1B0;
        rght_ld = 12'h000;
        step();
        check_out("dismount", 1'b0, 1'b1);
        step();
        check_out("dismount_hold", 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
